// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM state encoding
// and the smallest divisor the divider can produce a clock from.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_divider_prog_if.sv
// Signal bundle for the divider's control and status signals; master drives
// the run/load controls, slave returns the divided clock and status.
interface clk_divider_prog_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             div_pend;
    logic             div_err;
    logic [DIV_W-1:0] div_cur;
    logic             running;

    modport master (
        output en, div_val, div_load,
        input  clk_out, tick, div_pend, div_err, div_cur, running
    );

    modport slave (
        input  en, div_val, div_load,
        output clk_out, tick, div_pend, div_err, div_cur, running
    );
endinterface

// File: rtl/clk_divider_prog.sv
// Programmable integer clock divider: registered divided clock with a period
// tick, run/drain control and glitch-free divisor changes at period boundaries.
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 2
) (
    input  logic             i_clk_in,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div_val,
    input  logic             i_div_load,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_div_pend,
    output logic             o_div_err,
    output logic [DIV_W-1:0] o_div_cur,
    output logic             o_running
);

    state_t           state_q;
    logic [DIV_W-1:0] cnt_q;
    logic             clk_q;
    logic             tick_q;
    logic             running_q;

    logic [DIV_W-1:0] div_cur_q;
    logic [DIV_W-1:0] pend_val_q;
    logic             pend_q;
    logic             err_q;

    logic             wrap;
    logic             apply;
    logic             load_ok;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] half_n;

    // A period ends on the cycle the counter sits at N-1; that is the only
    // point (besides STOP) where a new divisor may take over.
    assign wrap    = (state_q != ST_STOP) && (cnt_q == div_cur_q - DIV_W'(1));
    assign apply   = pend_q && (wrap || (state_q == ST_STOP));
    assign load_ok = i_div_load && (i_div_val >= DIV_W'(DIV_MIN));
    assign cnt_inc = cnt_q + DIV_W'(1);
    // ceil(N/2) without needing an extra carry bit
    assign half_n  = (div_cur_q >> 1) + DIV_W'(div_cur_q[0]);

    always_ff @(posedge i_clk_in or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_STOP;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    cnt_q     <= '0;
                    clk_q     <= i_en;
                    tick_q    <= i_en;
                    running_q <= i_en;
                    state_q   <= i_en ? ST_RUN : ST_STOP;
                end
                default: begin
                    if (wrap) begin
                        cnt_q     <= '0;
                        clk_q     <= i_en;
                        tick_q    <= i_en;
                        running_q <= i_en;
                        state_q   <= i_en ? ST_RUN : ST_STOP;
                    end else begin
                        cnt_q     <= cnt_inc;
                        clk_q     <= (cnt_inc < half_n);
                        tick_q    <= 1'b0;
                        running_q <= 1'b1;
                        state_q   <= i_en ? ST_RUN : ST_DRAIN;
                    end
                end
            endcase
        end
    end

    // A load landing on the apply edge still wins the pending slot, while
    // the previously pending value becomes the divisor in force.
    always_ff @(posedge i_clk_in or posedge i_rst) begin
        if (i_rst) begin
            div_cur_q  <= DIV_W'(DIV_RST);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= i_div_load && !load_ok;
            if (apply) begin
                div_cur_q <= pend_val_q;
            end
            if (load_ok) begin
                pend_val_q <= i_div_val;
                pend_q     <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign o_clk_out  = clk_q;
    assign o_tick     = tick_q;
    assign o_running  = running_q;
    assign o_div_pend = pend_q;
    assign o_div_err  = err_q;
    assign o_div_cur  = div_cur_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Randomised self-checking bench for clk_divider_prog against a period-queue
// reference model, plus directed boundary scenarios.
module tb_clk_divider_prog;

    localparam int DIV_W   = 8;
    localparam int DIV_RST = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk_divider_prog_if #(.DIV_W(DIV_W)) bus ();

    clk_divider_prog #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) dut (
        .i_clk_in   (clk),
        .i_rst      (rst),
        .i_en       (bus.en),
        .i_div_val  (bus.div_val),
        .i_div_load (bus.div_load),
        .o_clk_out  (bus.clk_out),
        .o_tick     (bus.tick),
        .o_div_pend (bus.div_pend),
        .o_div_err  (bus.div_err),
        .o_div_cur  (bus.div_cur),
        .o_running  (bus.running)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each started period is expanded into a queue of
    // {clk, tick} samples; the divider is running while samples remain.
    int         m_n;
    int         m_per_n;
    bit         m_pend;
    int         m_pend_val;
    bit         m_err;
    logic [1:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_n        = DIV_RST;
        m_per_n    = DIV_RST;
        m_pend     = 1'b0;
        m_pend_val = 0;
        m_err      = 1'b0;
    endtask

    task automatic model_edge();
        int val;
        val = int'(bus.div_val);
        if (m_q.size() > 0) void'(m_q.pop_front());
        if (m_q.size() == 0) begin
            if (m_pend) begin
                m_n    = m_pend_val;
                m_pend = 1'b0;
            end
            if (bus.en) begin
                for (int p = 0; p < m_n; p++) m_q.push_back({p < (m_n + 1) / 2, p == 0});
                m_per_n = m_n;
            end
        end
        m_err = bus.div_load && (val < 2);
        if (bus.div_load && (val >= 2)) begin
            m_pend     = 1'b1;
            m_pend_val = val;
        end
    endtask

    function automatic int m_pos();
        return (m_q.size() > 0) ? (m_per_n - m_q.size()) : -1;
    endfunction

    task automatic check_all();
        logic [1:0] f;
        f = (m_q.size() > 0) ? m_q[0] : 2'b00;
        chk("clk_out",  32'(bus.clk_out),  32'(f[1]));
        chk("tick",     32'(bus.tick),     32'(f[0]));
        chk("running",  32'(bus.running),  32'(m_q.size() > 0));
        chk("div_pend", 32'(bus.div_pend), 32'(m_pend));
        chk("div_err",  32'(bus.div_err),  32'(m_err));
        chk("div_cur",  32'(bus.div_cur),  32'(m_n));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_all();
        bus.div_load = 1'b0;
    endtask

    task automatic load(input int v);
        bus.div_val  = DIV_W'(v);
        bus.div_load = 1'b1;
        $display("load val=%0d en=%0d pos=%0d n=%0d", v, bus.en, m_pos(), m_n);
        step();
    endtask

    task automatic wait_pos(input int n, input int p);
        int budget;
        budget = 600;
        while (!(m_q.size() > 0 && m_per_n == n && m_pos() == p) && budget > 0) begin
            step();
            budget--;
        end
        chk("wait_pos_budget", 32'(budget > 0), 32'(1));
        chk("wait_pos_div_cur", 32'(bus.div_cur), 32'(n));
    endtask

    task automatic wait_stop();
        int budget;
        budget = 600;
        while (m_q.size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        chk("wait_stop_budget", 32'(budget > 0), 32'(1));
        chk("stopped_running", 32'(bus.running), 32'(0));
    endtask

    task automatic async_rst();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_clk_out_now", 32'(bus.clk_out), 32'(0));
        $display("async reset at %0t", $time);
        step();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int toggles;
        int ticks;
        logic prev;
        int r;
        int v;

        bus.en       = 1'b0;
        bus.div_val  = '0;
        bus.div_load = 1'b0;
        model_reset();
        step();
        step();
        chk("reset_div_cur", 32'(bus.div_cur), 32'(DIV_RST));
        #2;
        rst = 1'b0;

        // Default divisor 2: toggles every cycle, tick every other cycle
        bus.en  = 1'b1;
        toggles = 0;
        ticks   = 0;
        prev    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i > 0 && bus.clk_out != prev) toggles++;
            if (bus.tick) ticks++;
            prev = bus.clk_out;
        end
        chk("n2_toggles", 32'(toggles), 32'(19));
        chk("n2_ticks", 32'(ticks), 32'(10));
        bus.en = 1'b0;
        wait_stop();

        // Load 5 mid-period of N=4
        load(4);
        step();
        chk("stop_apply_cur", 32'(bus.div_cur), 32'(4));
        bus.en = 1'b1;
        wait_pos(4, 1);
        load(5);
        chk("pend_after_load5", 32'(bus.div_pend), 32'(1));
        wait_pos(5, 0);
        chk("pend_cleared_at_wrap", 32'(bus.div_pend), 32'(0));
        for (int i = 0; i < 12; i++) step();

        // Last pending load wins
        wait_pos(5, 1);
        load(6);
        load(9);
        wait_pos(9, 0);
        chk("last_wins_cur", 32'(bus.div_cur), 32'(9));

        // Illegal divisors rejected
        load(1);
        chk("err_on_1", 32'(bus.div_err), 32'(1));
        chk("err1_cur", 32'(bus.div_cur), 32'(9));
        chk("err1_pend", 32'(bus.div_pend), 32'(0));
        step();
        chk("err_one_cycle", 32'(bus.div_err), 32'(0));
        load(0);
        chk("err_on_0", 32'(bus.div_err), 32'(1));
        chk("err0_cur", 32'(bus.div_cur), 32'(9));

        // N=7 drain, then drain interrupted by re-enable
        load(7);
        wait_pos(7, 2);
        bus.en = 1'b0;
        wait_stop();
        for (int i = 0; i < 5; i++) step();
        chk("drain_stays_low", 32'(bus.clk_out), 32'(0));
        bus.en = 1'b1;
        wait_pos(7, 2);
        bus.en = 1'b0;
        wait_pos(7, 4);
        bus.en = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // Reset mid-period of N=8
        load(8);
        wait_pos(8, 3);
        async_rst();
        chk("post_rst_cur", 32'(bus.div_cur), 32'(DIV_RST));
        step();
        chk("restart_clk", 32'(bus.clk_out), 32'(1));
        chk("restart_tick", 32'(bus.tick), 32'(1));

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, 9));
                if (r < 2) v = r;
                else if (r == 9) v = int'($urandom_range(100, 255));
                else v = int'($urandom_range(2, 12));
                load(v);
            end else begin
                step();
            end
            if ($urandom_range(0, 199) == 0) async_rst();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
